// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: instruction-dependent, lw 5, sw/R/I/jal 4, beq 3, unknown opcode 2 cycles FETCH-to-FETCH.
// Backpressure: none; the FSM advances every cycle and memory is assumed single-cycle.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   opcode      - instruction register bits [6:0], consulted in DECODE and MEMADR
//   zero        - ALU zero flag, consulted in BEQ
//   pc_write, adr_src, mem_write, ir_write, reg_write      - datapath enables/selects
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src      - 2-bit mux selects / ALU decoder op
//   state       - current state encoding, for debug
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t cur_state;
    state_t nxt_state;

    // Raw per-state decode; strobes are gated with rst_n below.
    logic pc_update;
    logic branch;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state     = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;

        case (cur_state)
            S_FETCH: begin
                // PC+4 computed on the ALU and written straight back through result mux.
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
                nxt_state    = S_DECODE;
            end

            S_DECODE: begin
                // Precompute old_pc + imm so BEQ/JAL find the target in the ALU out register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYP:      nxt_state = S_EXECUTER;
                    OP_ITYP:      nxt_state = S_EXECUTEI;
                    OP_JAL:       nxt_state = S_JAL;
                    OP_BEQ:       nxt_state = S_BEQ;
                    default:      nxt_state = S_FETCH;
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // Any opcode other than lw/sw here means the IR changed under us;
                // abandon the access rather than guess which one was meant.
                case (opcode)
                    OP_LW:   nxt_state = S_MEMREAD;
                    OP_SW:   nxt_state = S_MEMWRITE;
                    default: nxt_state = S_FETCH;
                endcase
            end

            S_MEMREAD: begin
                adr_src   = 1'b1;
                nxt_state = S_MEMWB;
            end

            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                nxt_state     = S_FETCH;
            end

            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                nxt_state     = S_FETCH;
            end

            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end

            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end

            S_ALUWB: begin
                // result_src 00 selects the ALU out register holding the op result.
                reg_write_raw = 1'b1;
                nxt_state     = S_FETCH;
            end

            S_JAL: begin
                // PC <= target (ALU out from DECODE); ALU computes old_pc + 4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt_state = S_ALUWB;
            end

            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                nxt_state = S_FETCH;
            end

            default: begin
                // Encodings 11-15: drive nothing, recover to FETCH.
                nxt_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Strobes: suppressed while reset is held so nothing is written during
    // the reset window even though the state register reads FETCH.
    // ------------------------------------------------------------------
    assign pc_write  = rst_n & (pc_update | (branch & zero));
    assign ir_write  = rst_n & ir_write_raw;
    assign mem_write = rst_n & mem_write_raw;
    assign reg_write = rst_n & reg_write_raw;

    // ------------------------------------------------------------------
    // Immediate format straight from the opcode bits.
    // ------------------------------------------------------------------
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Inputs change and outputs are sampled 1-2 time units after the falling clock edge.
// Each task starts and ends just after a falling edge with the FSM in FETCH.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        opcode = 7'b0000000;
        zero   = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
        checks++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin errors++; $display("FAIL rst_strobes: got %b expected 0000", {pc_write, ir_write, mem_write, reg_write}); end
        checks++; if (alu_src_b !== 2'b10) begin errors++; $display("FAIL rst_alu_src_b: got %b expected 10", alu_src_b); end
        checks++; if (result_src !== 2'b10) begin errors++; $display("FAIL rst_result_src: got %b expected 10", result_src); end
        checks++; if ({adr_src, alu_src_a, alu_op} !== 5'b0) begin errors++; $display("FAIL rst_other: got %b expected 00000", {adr_src, alu_src_a, alu_op}); end
        // Clock edges while reset is held must not advance the FSM.
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_hold_state: got %0d expected 0", state); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL rel_ir_write: got %b expected 1", ir_write); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rel_pc_write: got %b expected 1", pc_write); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rel_state: got %0d expected 0", state); end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5];
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        opcode = 7'b0000011; zero = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
            checks++; if (reg_write !== (i == 4)) begin errors++; $display("FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, (i == 4)); end
            checks++; if (alu_op !== 2'b00) begin errors++; $display("FAIL lw_alu_op[%0d]: got %b expected 00", i, alu_op); end
            if (i == 3) begin
                checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL lw_adr_src: got %b expected 1", adr_src); end
                // Opcode is no longer looked at once MEMREAD is reached.
                opcode = 7'b1111111;
            end
            if (i == 4) begin
                checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL lw_result_src: got %b expected 01", result_src); end
            end
            @(negedge clk); #1;
        end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d expected 0", state); end
    endtask

    task automatic test_sw();
        logic [3:0] exp_s [4];
        int mw_count;
        exp_s = '{4'd0, 4'd1, 4'd2, 4'd5};
        mw_count = 0;
        opcode = 7'b0100011; #1;
        checks++; if (imm_src !== 2'b01) begin errors++; $display("FAIL sw_imm_src: got %b expected 01", imm_src); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
            if (mem_write === 1'b1) mw_count++;
            if (i == 3) begin
                checks++; if ({mem_write, adr_src} !== 2'b11) begin errors++; $display("FAIL sw_memwrite_adr: got %b expected 11", {mem_write, adr_src}); end
            end
            checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL sw_reg_write[%0d]: got %b expected 0", i, reg_write); end
            @(negedge clk); #1;
        end
        checks++; if (mw_count !== 1) begin errors++; $display("FAIL sw_mem_write_count: got %0d expected 1", mw_count); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_end_state: got %0d expected 0", state); end
    endtask

    task automatic test_alu_ops();
        logic [3:0] exp_s [4];
        for (int k = 0; k < 2; k++) begin
            // k=0: R-type, k=1: I-type ALU
            exp_s = '{4'd0, 4'd1, (k == 0) ? 4'd6 : 4'd8, 4'd7};
            opcode = (k == 0) ? 7'b0110011 : 7'b0010011; #1;
            for (int i = 0; i < 4; i++) begin
                checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL alu%0d_state[%0d]: got %0d expected %0d", k, i, state, exp_s[i]); end
                checks++; if (reg_write !== (i == 3)) begin errors++; $display("FAIL alu%0d_reg_write[%0d]: got %b expected %b", k, i, reg_write, (i == 3)); end
                if (i == 2) begin
                    checks++; if (alu_op !== 2'b10) begin errors++; $display("FAIL alu%0d_alu_op: got %b expected 10", k, alu_op); end
                    checks++; if (alu_src_a !== 2'b10) begin errors++; $display("FAIL alu%0d_alu_src_a: got %b expected 10", k, alu_src_a); end
                    checks++; if (alu_src_b !== ((k == 0) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL alu%0d_alu_src_b: got %b expected %b", k, alu_src_b, ((k == 0) ? 2'b00 : 2'b01)); end
                end
                if (i == 3) begin
                    checks++; if (result_src !== 2'b00) begin errors++; $display("FAIL alu%0d_result_src: got %b expected 00", k, result_src); end
                end
                @(negedge clk); #1;
            end
            checks++; if (state !== 4'd0) begin errors++; $display("FAIL alu%0d_end_state: got %0d expected 0", k, state); end
        end
    endtask

    task automatic test_beq();
        logic [3:0] exp_s [3];
        exp_s = '{4'd0, 4'd1, 4'd10};
        for (int k = 0; k < 2; k++) begin
            // k=0: taken (zero=1), k=1: not taken (zero=0)
            opcode = 7'b1100011;
            zero   = (k == 0);
            #1;
            checks++; if (imm_src !== 2'b10) begin errors++; $display("FAIL beq%0d_imm_src: got %b expected 10", k, imm_src); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", k, i, state, exp_s[i]); end
                checks++; if (pc_write !== ((i == 0) || (i == 2 && k == 0))) begin errors++; $display("FAIL beq%0d_pc_write[%0d]: got %b expected %b", k, i, pc_write, ((i == 0) || (i == 2 && k == 0))); end
                if (i == 2) begin
                    checks++; if (alu_op !== 2'b01) begin errors++; $display("FAIL beq%0d_alu_op: got %b expected 01", k, alu_op); end
                end
                @(negedge clk); #1;
            end
            checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq%0d_end_state: got %0d expected 0", k, state); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0] exp_s [4];
        exp_s = '{4'd0, 4'd1, 4'd9, 4'd7};
        opcode = 7'b1101111; #1;
        checks++; if (imm_src !== 2'b11) begin errors++; $display("FAIL jal_imm_src: got %b expected 11", imm_src); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
            checks++; if (pc_write !== (i == 0 || i == 2)) begin errors++; $display("FAIL jal_pc_write[%0d]: got %b expected %b", i, pc_write, (i == 0 || i == 2)); end
            if (i == 2) begin
                checks++; if ({alu_src_a, alu_src_b} !== 4'b0110) begin errors++; $display("FAIL jal_alu_src: got %b expected 0110", {alu_src_a, alu_src_b}); end
            end
            @(negedge clk); #1;
        end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL jal_end_state: got %0d expected 0", state); end
    endtask

    task automatic test_unknown();
        opcode = 7'b1111111; #1;
        checks++; if (imm_src !== 2'b00) begin errors++; $display("FAIL unk_imm_src: got %b expected 00", imm_src); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL unk_state0: got %0d expected 0", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL unk_state1: got %0d expected 1", state); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL unk_state2: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid();
        opcode = 7'b0000011; #1;
        repeat (3) begin @(negedge clk); #1; end
        checks++; if (state !== 4'd3) begin errors++; $display("FAIL mid_pre_state: got %0d expected 3", state); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", state); end
        checks++; if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin errors++; $display("FAIL mid_strobes: got %b expected 0000", {pc_write, ir_write, mem_write, reg_write}); end
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if ({state, reg_write} !== 5'b0) begin errors++; $display("FAIL mid_hold: got state %0d reg_write %b expected 0 0", state, reg_write); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if ({state, ir_write} !== 5'b00001) begin errors++; $display("FAIL mid_release: got state %0d ir_write %b expected 0 1", state, ir_write); end
        @(negedge clk); #1;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL mid_restart: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu_ops();
        test_beq();
        test_jal();
        test_unknown();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
